// File: rtl/cpu_pkg.sv
// Shared encodings for the pipeline hazard logic: operand-mux select codes,
// result-kind codes and the "cycles until result is available" constants.
package cpu_pkg;

  // Operand mux select codes
  localparam logic [2:0] SelOrig  = 3'b000;  // original register-file operand
  localparam logic [2:0] SelEPc8  = 3'b001;  // E-stage PC+8
  localparam logic [2:0] SelMAlu  = 3'b010;  // M-stage ALU result
  localparam logic [2:0] SelMPc8  = 3'b011;  // M-stage PC+8
  localparam logic [2:0] SelWData = 3'b100;  // W-stage write data

  // Result source of an instruction
  localparam logic [1:0] KindAlu  = 2'b00;
  localparam logic [1:0] KindMem  = 2'b01;
  localparam logic [1:0] KindLink = 2'b10;
  localparam logic [1:0] KindNone = 2'b11;

  // Cycles (counted from E) before the result can be forwarded
  localparam logic [1:0] TnewZero = 2'd0;
  localparam logic [1:0] TnewAlu  = 2'd1;
  localparam logic [1:0] TnewMem  = 2'd2;

  // tuse value meaning the operand is not read at all
  localparam logic [1:0] TuseUnused = 2'd3;

  function automatic logic [1:0] tnew_of(input logic [1:0] kind);
    case (kind)
      KindMem: return TnewMem;
      KindAlu: return TnewAlu;
      default: return TnewZero;
    endcase
  endfunction

  function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
    return (tnew == TnewZero) ? TnewZero : tnew - 2'd1;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Producer lookup for one source register against the E, M and W slots.
// Returns the forwarding select of the nearest producer and whether that
// producer's result is available no later than the consumer needs it.
module fwd_match
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]      i_src,
  input  logic [1:0]             i_tuse,
  input  logic [2:0]             i_slot_en,  // bit 0 = E, 1 = M, 2 = W
  input  logic [2:0]             i_valid,
  input  logic [2:0][ADDR_W-1:0] i_dst,
  input  logic [2:0][1:0]        i_kind,
  input  logic [2:0][1:0]        i_tnew,
  output logic [2:0]             o_sel,
  output logic                   o_ready
);

  logic [2:0] w_hit;

  // Per-slot producer match; register 0 never matches
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < 3; i++) begin
      w_hit[i] = i_slot_en[i] & i_valid[i] & (i_dst[i] == i_src) &
                 (i_src != '0) & (i_kind[i] != KindNone);
    end
  end

  // Nearest producer wins; an unready producer still blocks older stages
  always_comb begin
    o_sel   = SelOrig;
    o_ready = 1'b1;
    if (w_hit[0]) begin
      o_ready = (i_tnew[0] <= i_tuse);
      if (i_tnew[0] == TnewZero && i_kind[0] == KindLink) o_sel = SelEPc8;
    end else if (w_hit[1]) begin
      o_ready = (i_tnew[1] <= i_tuse);
      if (i_tnew[1] == TnewZero) begin
        if (i_kind[1] == KindAlu)       o_sel = SelMAlu;
        else if (i_kind[1] == KindLink) o_sel = SelMPc8;
      end
    end else if (w_hit[2]) begin
      o_ready = (i_tnew[2] <= i_tuse);
      if (i_tnew[2] == TnewZero) o_sel = SelWData;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall and forwarding control for a 5-stage pipeline. Tracks destination,
// kind and time-to-result of the instructions in E, M and W, and derives
// the D-stage stall plus the operand mux selects for D, E and M.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic [1:0]        d_tuse_rs,
  input  logic [1:0]        d_tuse_rt,
  input  logic [ADDR_W-1:0] d_dst,
  input  logic [1:0]        d_kind,
  output logic              stall,
  output logic [2:0]        sel_d_rs,
  output logic [2:0]        sel_d_rt,
  output logic [2:0]        sel_e_rs,
  output logic [2:0]        sel_e_rt,
  output logic [2:0]        sel_m_rt
);

  // Slot index 0 = E, 1 = M, 2 = W. Only source fields that some mux
  // consults are kept (E rs/rt, M rt).
  logic [2:0]             r_valid;
  logic [2:0][ADDR_W-1:0] r_dst;
  logic [2:0][1:0]        r_kind;
  logic [2:0][1:0]        r_tnew;
  logic [ADDR_W-1:0]      r_e_rs, r_e_rt, r_m_rt;

  logic w_rdy_d_rs, w_rdy_d_rt, w_rdy_e_rs, w_rdy_e_rt, w_rdy_m_rt;
  logic w_load;

  // Stall when a consumed D operand's nearest producer is still too late
  always_comb begin
    stall = d_valid &
            (((d_tuse_rs != TuseUnused) & ~w_rdy_d_rs) |
             ((d_tuse_rt != TuseUnused) & ~w_rdy_d_rt));
    w_load = d_valid & ~stall;
  end

  // Slot pipeline: E takes D or a bubble, M and W shift unconditionally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_dst   <= '0;
      r_kind  <= {3{KindNone}};
      r_tnew  <= '0;
      r_e_rs  <= '0;
      r_e_rt  <= '0;
      r_m_rt  <= '0;
    end else begin
      r_valid[0] <= w_load;
      r_dst[0]   <= w_load ? d_dst : '0;
      r_kind[0]  <= w_load ? d_kind : KindNone;
      r_tnew[0]  <= w_load ? tnew_of(d_kind) : TnewZero;
      r_e_rs     <= w_load ? d_rs : '0;
      r_e_rt     <= w_load ? d_rt : '0;
      r_valid[2:1] <= r_valid[1:0];
      r_dst[2:1]   <= r_dst[1:0];
      r_kind[2:1]  <= r_kind[1:0];
      r_tnew[1]    <= tnew_dec(r_tnew[0]);
      r_tnew[2]    <= tnew_dec(r_tnew[1]);
      r_m_rt       <= r_e_rt;
    end
  end

  fwd_match #(.ADDR_W(ADDR_W)) u_fwd_d_rs (
    .i_src(d_rs), .i_tuse(d_tuse_rs), .i_slot_en(3'b111),
    .i_valid(r_valid), .i_dst(r_dst), .i_kind(r_kind), .i_tnew(r_tnew),
    .o_sel(sel_d_rs), .o_ready(w_rdy_d_rs)
  );

  fwd_match #(.ADDR_W(ADDR_W)) u_fwd_d_rt (
    .i_src(d_rt), .i_tuse(d_tuse_rt), .i_slot_en(3'b111),
    .i_valid(r_valid), .i_dst(r_dst), .i_kind(r_kind), .i_tnew(r_tnew),
    .o_sel(sel_d_rt), .o_ready(w_rdy_d_rt)
  );

  // E and M consumers need their operand now, hence tuse = 0
  fwd_match #(.ADDR_W(ADDR_W)) u_fwd_e_rs (
    .i_src(r_e_rs), .i_tuse(2'd0), .i_slot_en(3'b110),
    .i_valid(r_valid), .i_dst(r_dst), .i_kind(r_kind), .i_tnew(r_tnew),
    .o_sel(sel_e_rs), .o_ready(w_rdy_e_rs)
  );

  fwd_match #(.ADDR_W(ADDR_W)) u_fwd_e_rt (
    .i_src(r_e_rt), .i_tuse(2'd0), .i_slot_en(3'b110),
    .i_valid(r_valid), .i_dst(r_dst), .i_kind(r_kind), .i_tnew(r_tnew),
    .o_sel(sel_e_rt), .o_ready(w_rdy_e_rt)
  );

  fwd_match #(.ADDR_W(ADDR_W)) u_fwd_m_rt (
    .i_src(r_m_rt), .i_tuse(2'd0), .i_slot_en(3'b100),
    .i_valid(r_valid), .i_dst(r_dst), .i_kind(r_kind), .i_tnew(r_tnew),
    .o_sel(sel_m_rt), .o_ready(w_rdy_m_rt)
  );

  // E/M readiness is guaranteed by the D-stage stall, so it is not consumed
  logic w_unused_rdy;
  assign w_unused_rdy = w_rdy_e_rs ^ w_rdy_e_rt ^ w_rdy_m_rt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expected outputs are queued when D-stage
// stimulus is driven and compared mid-cycle against the DUT.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_kind;
  logic       stall;
  logic [2:0] sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt, sel_m_rt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic       stall;
    logic [2:0] d_rs, d_rt, e_rs, e_rt, m_rt;
  } exp_t;
  exp_t sb_q[$];

  hazard_unit #(.ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_kind(d_kind), .stall(stall),
    .sel_d_rs(sel_d_rs), .sel_d_rt(sel_d_rt), .sel_e_rs(sel_e_rs),
    .sel_e_rt(sel_e_rt), .sel_m_rt(sel_m_rt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1);
  end

  task automatic drive_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] trs, input logic [1:0] trt,
                         input logic [4:0] dst, input logic [1:0] kind);
    d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
    d_dst = dst; d_kind = kind;
  endtask

  task automatic nop();
    drive_d(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'b11);
  endtask

  task automatic expect_out(input string tag, input logic st, input logic [2:0] drs,
                            input logic [2:0] drt, input logic [2:0] ers,
                            input logic [2:0] ert, input logic [2:0] mrt);
    exp_t e;
    e.tag = tag; e.stall = st; e.d_rs = drs; e.d_rt = drt;
    e.e_rs = ers; e.e_rt = ert; e.m_rt = mrt;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard: observed empty queue, expected an entry");
      return;
    end
    e = sb_q.pop_front();
    assert (stall === e.stall) else begin
      n_errors++;
      $error("FAIL %s.stall: observed %b expected %b", e.tag, stall, e.stall);
    end
    n_checks++;
    assert (sel_d_rs === e.d_rs) else begin
      n_errors++;
      $error("FAIL %s.sel_d_rs: observed %b expected %b", e.tag, sel_d_rs, e.d_rs);
    end
    n_checks++;
    assert (sel_d_rt === e.d_rt) else begin
      n_errors++;
      $error("FAIL %s.sel_d_rt: observed %b expected %b", e.tag, sel_d_rt, e.d_rt);
    end
    n_checks++;
    assert (sel_e_rs === e.e_rs) else begin
      n_errors++;
      $error("FAIL %s.sel_e_rs: observed %b expected %b", e.tag, sel_e_rs, e.e_rs);
    end
    n_checks++;
    assert (sel_e_rt === e.e_rt) else begin
      n_errors++;
      $error("FAIL %s.sel_e_rt: observed %b expected %b", e.tag, sel_e_rt, e.e_rt);
    end
    n_checks++;
    assert (sel_m_rt === e.m_rt) else begin
      n_errors++;
      $error("FAIL %s.sel_m_rt: observed %b expected %b", e.tag, sel_m_rt, e.m_rt);
    end
  endtask

  // Compare mid-cycle, then advance past the next rising edge
  task automatic cycle_check();
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    nop();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // kinds: 00 ALU, 01 MEM, 10 LINK, 11 none
  initial begin
    reset = 1'b1;
    nop();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expect_out("reset", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();

    // ALU back-to-back: add $8 ; sub reads $8 at tuse 1
    drive_d(1'b1, 5'd2, 5'd3, 2'd1, 2'd1, 5'd8, 2'b00);
    expect_out("alu_add", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    drive_d(1'b1, 5'd8, 5'd4, 2'd1, 2'd1, 5'd12, 2'b00);
    expect_out("alu_sub_d", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    nop();
    expect_out("alu_sub_e", 1'b0, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000);
    cycle_check();
    flush();

    // Load-use: lw $9 ; beq reads $9 at tuse 0 -> two stall cycles
    drive_d(1'b1, 5'd5, 5'd0, 2'd1, 2'd3, 5'd9, 2'b01);
    expect_out("lu_lw", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    drive_d(1'b1, 5'd9, 5'd6, 2'd0, 2'd0, 5'd0, 2'b11);
    expect_out("lu_stall1", 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    expect_out("lu_stall2", 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    expect_out("lu_fwd", 1'b0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    flush();

    // Load with tuse boundaries: tuse 3 ignored, tnew 2 vs tuse 2 is fine
    drive_d(1'b1, 5'd5, 5'd0, 2'd1, 2'd3, 5'd9, 2'b01);
    expect_out("tu_lw", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    drive_d(1'b1, 5'd9, 5'd9, 2'd3, 2'd2, 5'd0, 2'b11);
    expect_out("tu_ok", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    drive_d(1'b1, 5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'b11);
    expect_out("tu_m_stall", 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    flush();

    // jal $31 ; jr $31 -> E-stage PC+8, no stall
    drive_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'b10);
    expect_out("jal", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    drive_d(1'b1, 5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'b11);
    expect_out("jr", 1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    flush();

    // Nearest producer: A writes $10, B writes $10 (and reads it as rt)
    drive_d(1'b1, 5'd1, 5'd0, 2'd1, 2'd3, 5'd10, 2'b00);
    expect_out("np_a", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    drive_d(1'b1, 5'd2, 5'd10, 2'd1, 2'd3, 5'd10, 2'b00);
    expect_out("np_b", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    nop();
    expect_out("np_e_fwd", 1'b0, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000);
    cycle_check();
    drive_d(1'b1, 5'd10, 5'd10, 2'd1, 2'd0, 5'd0, 2'b11);
    expect_out("np_d_fwd", 1'b0, 3'b010, 3'b010, 3'b000, 3'b000, 3'b100);
    cycle_check();
    flush();

    // Register 0: a load to $0 is never a producer
    drive_d(1'b1, 5'd0, 5'd0, 2'd1, 2'd3, 5'd0, 2'b01);
    expect_out("r0_prod", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    drive_d(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'b11);
    expect_out("r0_cons", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    flush();

    // Reset during a load-use stall
    drive_d(1'b1, 5'd5, 5'd0, 2'd1, 2'd3, 5'd9, 2'b01);
    expect_out("rs_lw", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();
    drive_d(1'b1, 5'd9, 5'd6, 2'd0, 2'd0, 5'd0, 2'b11);
    expect_out("rs_stall", 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    check_out();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_out("rs_after", 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    cycle_check();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
